// File: rtl/mux16_scan_ctrl_pkg.sv
// ============================================================================
// mux_scan_pkg : shared types and select helpers for the 16-bit scan controller
// Revision 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   localparam int NBITS = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } scan_state_t;

   localparam logic [SEL_W-1:0] SEL_MAX = '1;

   function automatic logic [SEL_W-1:0] sel_first(input bit descend);
      return descend ? SEL_MAX : '0;
   endfunction

   function automatic logic [SEL_W-1:0] sel_last(input bit descend);
      return descend ? '0 : SEL_MAX;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux16_scan_ctrl_sel_counter.sv
// ============================================================================
// sel_counter : loadable up/down select counter with end-of-scan flag
// Revision 1.0
// ============================================================================
`default_nettype none

module sel_counter
   import mux_scan_pkg::*;
#(
   parameter logic [SEL_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SEL_W-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [SEL_W-1:0] cnt,
   output logic             at_last
);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   // load outranks counting so a new scan start never races a step
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = dir ? (cnt_q - SEL_W'(1)) : (cnt_q + SEL_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign at_last = (cnt_q == sel_last(dir));

endmodule

`default_nettype wire

// File: rtl/mux16_scan_ctrl.sv
// ============================================================================
// mux16_scan_ctrl : parallel-to-serial scan controller feeding a 16:1 bit mux
// Revision 1.0
// ============================================================================
`default_nettype none

module mux16_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter bit               DESCEND  = 1'b0,
   parameter logic [SEL_W-1:0] IDLE_SEL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [NBITS-1:0] in_word,
   output logic             in_ready,
   input  logic             abort,
   input  logic             bit_ready,
   output logic             bit_valid,
   output logic             bit_last,
   output logic [0:NBITS-1] j_word,
   output logic [SEL_W-1:0] sel,
   output logic             busy
);

   localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(DESCEND);

   scan_state_t      state_q;
   logic             bit_valid_q;
   logic             busy_q;
   logic [0:NBITS-1] j_word_q;
   logic [0:NBITS-1] j_word_d;

   logic             shifting;
   logic             at_last;
   logic             kill;
   logic             beat;
   logic             accept;
   logic             done;
   logic             cnt_load;
   logic             cnt_en;
   logic [SEL_W-1:0] cnt_load_val;

   assign shifting = (state_q == SHIFT);
   assign kill     = shifting & abort;
   assign bit_last = shifting & at_last;
   assign in_ready = ~kill & (~shifting | (bit_last & bit_ready));
   assign accept   = in_valid & in_ready;
   assign beat     = bit_valid_q & bit_ready & ~kill;
   assign done     = beat & bit_last & ~accept;

   // j_word is declared ascending, so copy bit-by-bit to keep in_word[i] on J[i]
   always_comb begin
      j_word_d = j_word_q;
      for (int i = 0; i < NBITS; i++) begin
         j_word_d[i] = in_word[i];
      end
   end

   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = IDLE_SEL;
      cnt_en       = 1'b0;
      if (kill || done) begin
         cnt_load = 1'b1;
      end else if (accept) begin
         cnt_load     = 1'b1;
         cnt_load_val = SEL_FIRST;
      end else begin
         cnt_en = beat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         j_word_q    <= '0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (accept) begin
            j_word_q <= j_word_d;
         end
         if (kill || done) begin
            state_q     <= IDLE;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else if (accept) begin
            state_q     <= SHIFT;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
         end
      end
   end

   sel_counter #(
      .RST_VAL (IDLE_SEL)
   ) u_sel_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .dir      (DESCEND),
      .cnt      (sel),
      .at_last  (at_last)
   );

   assign bit_valid = bit_valid_q;
   assign busy      = busy_q;
   assign j_word    = j_word_q;

endmodule

`default_nettype wire
